fft_butterfly_per: RTL and testbench
====================================

# fft_butterfly_per

Memory-mapped radix-2 decimation-in-time butterfly accelerator on the openMSP430 peripheral bus. It replaces the software butterfly inner loop of the 16-point FFT. The CPU loads operands A, B and twiddle W (Q15 complex). The block computes X = A + B·W and Y = A − B·W with a single time-shared 16×16 multiplier, then raises DONE and an optional interrupt. Its per_dout is OR-ed into the CPU per_dout bus alongside gpio, timerA and uart.

## Interface
- BASE_ADDR, 15'h0100: byte base address. Must be 32-byte aligned. Decode is per_addr[13:4] == BASE_ADDR[14:5].
- mclk  in  1  main system clock
- reset_n  in  1  asynchronous, active-low reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  peripheral access enable
- per_we  in  2  byte write enables, high active
- per_dout  out  16  read data, 0 when not addressed
- irq_fft  out  1  interrupt, level = DONE & IE

## Operation
- Register map, byte offsets:
  - 0x00 AR, 0x02 AI, 0x04 BR, 0x06 BI, 0x08 WR, 0x0A WI: RW operands, byte-lane writable.
  - 0x0C CTRL: bit0 START (write-1 pulse, reads 0), bit1 SCALE, bit2 IE.
  - 0x0E STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 OVF (sticky, W1C).
  - 0x10 XR, 0x12 XI, 0x14 YR, 0x16 YI: RO results.
  - 0x18–0x1E: read 0, writes ignored.
- Reads are combinational: per_dout = reg when per_en & per_we==0 & address hit, else 16'h0000.
- While BUSY, writes to operands and START are ignored. CTRL SCALE/IE and STATUS clears are still accepted.
- FSM states: IDLE → M0 → M1 → M2 → M3 → SUM → IDLE.
  - IDLE: START write → M0. The same edge clears DONE.
  - M0: acc = BR·WR.
  - M1: acc −= BI·WI; latch Tr = (acc + 2^14) >>> 15.
  - M2: acc = BR·WI.
  - M3: acc += BI·WR; latch Ti likewise.
  - SUM: X = A + T, Y = A − T. If SCALE, apply >>> 1. Saturate to [−32768, 32767]; any clip sets OVF. Write results, set DONE.
- Widths: products are signed 32-bit, acc is signed 33-bit, T is signed 18-bit, sums are signed 19-bit before scale/saturate.
- Results hold until the next SUM. Operands are never modified by the block.

## Timing
- Reset: all registers, results, CTRL, STATUS = 0; FSM = IDLE; per_dout = 0; irq_fft = 0.
- START accepted at rising edge n → BUSY = 1 from n+1.
- Results and DONE valid after edge n+5; BUSY = 0 from the same edge. A new START is accepted at n+5 or later.
- DONE set and a W1C of DONE in the same cycle → set wins.
- irq_fft follows DONE & IE combinationally from registered bits, with no extra latency.
- reset_n asserted mid-computation: immediate return to IDLE. Partial results are discarded and all registers are cleared.

## Structure
- Shared package fft_pkg:
  - register offset localparams
  - Q15 width (16) and rounding constant (2^14)
  - FSM state encoding: fft_state_t {IDLE, M0, M1, M2, M3, SUM}
- Sub-module fft_bfly_mac: sequential signed 16×16 multiply-accumulate.
  - Inputs: operand select, clear/add/sub control.
  - Outputs: 33-bit acc.
- The top module holds the bus decode, registers, FSM, and sum/scale/saturate logic.

## Test plan
- Reset values: after reset, read all 12 implemented registers → 0x0000. irq_fft = 0. An unmapped read (BASE+0x1A) → 0.
- Identity twiddle: A=(0x4000,0), B=(0x2000,0), W=(0x7FFF,0), START → BUSY for 5 cycles, then X=(0x6000,0), Y=(0x2000,0), DONE=1, OVF=0.
- Rotation by −j: A=0, B=(0x2000,0), W=(0,0x8000) → X=(0x0000,0xE000), Y=(0x0000,0x2000).
- Saturation and scale: A=B=W=(0x7FFF,0), SCALE=0 → XR=0x7FFF, YR=0x0001, OVF=1. Clear OVF, rerun with SCALE=1 → XR=0x7FFE, YR=0x0000, OVF=0.
- Busy protection and interrupt:
  - Write AR=0x1234 and START during BUSY → both ignored; results match the original operands.
  - With IE=1, irq_fft rises on the DONE edge. Writing 0x0002 to STATUS drops irq_fft the next cycle.
- Reset mid-op: assert reset_n low at M2 → immediately BUSY=0, results 0, DONE=0. After release, a new START completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 butterfly peripheral: register map,
// Q15 constants, FSM/MAC encodings and small arithmetic helpers.
package fft_pkg;

   localparam int unsigned Q15_W = 16;
   localparam logic signed [33:0] RND_K = 34'sd16384;

   // Byte offsets from the peripheral base
   localparam logic [4:0] OFF_AR     = 5'h00;
   localparam logic [4:0] OFF_AI     = 5'h02;
   localparam logic [4:0] OFF_BR     = 5'h04;
   localparam logic [4:0] OFF_BI     = 5'h06;
   localparam logic [4:0] OFF_WR     = 5'h08;
   localparam logic [4:0] OFF_WI     = 5'h0A;
   localparam logic [4:0] OFF_CTRL   = 5'h0C;
   localparam logic [4:0] OFF_STATUS = 5'h0E;
   localparam logic [4:0] OFF_XR     = 5'h10;
   localparam logic [4:0] OFF_XI     = 5'h12;
   localparam logic [4:0] OFF_YR     = 5'h14;
   localparam logic [4:0] OFF_YI     = 5'h16;

   typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, SUM} fft_state_t;
   typedef enum logic [1:0] {MAC_HOLD, MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_t;
   typedef enum logic [1:0] {SEL_RR, SEL_II, SEL_RI, SEL_IR} mac_sel_t;

   function automatic logic [Q15_W-1:0] byte_merge(input logic [15:0] old_v,
                                                   input logic [15:0] din,
                                                   input logic [1:0]  we);
      return {we[1] ? din[15:8] : old_v[15:8], we[0] ? din[7:0] : old_v[7:0]};
   endfunction

   // Round-half-up back to Q15, keeping the 18-bit headroom of the sum path
   function automatic logic signed [17:0] q15_round(input logic signed [32:0] acc);
      logic signed [33:0] rnd;
      rnd = {acc[32], acc} + RND_K;
      return 18'(rnd >>> 15);
   endfunction

   // Returns {clipped, value}
   function automatic logic [16:0] sum_sat(input logic signed [15:0] a,
                                           input logic signed [17:0] t,
                                           input logic               sub,
                                           input logic               scale);
      logic signed [18:0] s;
      s = {{3{a[15]}}, a};
      if (sub) s = s - {t[17], t};
      else     s = s + {t[17], t};
      if (scale) s = s >>> 1;
      if (s > 19'sd32767)       return {1'b1, 16'h7FFF};
      else if (s < -19'sd32768) return {1'b1, 16'h8000};
      else                      return {1'b0, s[15:0]};
   endfunction

endpackage

// File: rtl/fft_bfly_mac.sv
// Time-shared signed 16x16 multiply-accumulate for the butterfly B*W product.
module fft_bfly_mac
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        br,
   input  logic [15:0]        bi,
   input  logic [15:0]        wr,
   input  logic [15:0]        wi,
   input  mac_sel_t           sel,
   input  mac_op_t            op,
   output logic signed [32:0] acc
);

   logic signed [15:0] ma, mb;
   logic signed [31:0] prod;
   logic signed [32:0] prod_x;

   always_comb begin
      ma = br;
      mb = wr;
      case (sel)
         SEL_RR: begin ma = br; mb = wr; end
         SEL_II: begin ma = bi; mb = wi; end
         SEL_RI: begin ma = br; mb = wi; end
         SEL_IR: begin ma = bi; mb = wr; end
         default: ;
      endcase
      prod   = ma * mb;
      prod_x = {prod[31], prod};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else begin
         case (op)
            MAC_LOAD: acc <= prod_x;
            MAC_ADD:  acc <= acc + prod_x;
            MAC_SUB:  acc <= acc - prod_x;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/fft_butterfly_per.sv
// openMSP430 peripheral computing X = A + B*W, Y = A - B*W in Q15 with one
// shared multiplier; bus decode, registers, FSM and sum/saturate live here.
module fft_butterfly_per
   import fft_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR = 15'h0100
) (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   output logic        irq_fft
);

   fft_state_t         state;
   logic [15:0]        ar, ai, br, bi, wr, wi;
   logic [15:0]        xr, xi, yr, yi;
   logic               scale, ie, done, ovf;
   logic signed [17:0] tr, ti;
   logic signed [32:0] acc;
   mac_op_t            mac_op;
   mac_sel_t           mac_sel;
   logic [16:0]        s_xr, s_xi, s_yr, s_yi;

   logic       hit, reg_wr, reg_rd, busy, start_req;
   logic [4:0] off;

   assign hit       = per_en && (per_addr[13:4] == BASE_ADDR[14:5]);
   assign off       = {per_addr[3:0], 1'b0};
   assign reg_wr    = hit && (per_we != 2'b00);
   assign reg_rd    = hit && (per_we == 2'b00);
   assign busy      = (state != IDLE);
   assign start_req = reg_wr && (off == OFF_CTRL) && per_we[0] && per_din[0];
   assign irq_fft   = done & ie;

   fft_bfly_mac u_mac (
      .clk   (mclk),
      .rst_n (reset_n),
      .br    (br),
      .bi    (bi),
      .wr    (wr),
      .wi    (wi),
      .sel   (mac_sel),
      .op    (mac_op),
      .acc   (acc)
   );

   always_comb begin
      mac_op  = MAC_HOLD;
      mac_sel = SEL_RR;
      case (state)
         M0: begin mac_op = MAC_LOAD; mac_sel = SEL_RR; end
         M1: begin mac_op = MAC_SUB;  mac_sel = SEL_II; end
         M2: begin mac_op = MAC_LOAD; mac_sel = SEL_RI; end
         M3: begin mac_op = MAC_ADD;  mac_sel = SEL_IR; end
         default: ;
      endcase
   end

   // Tr is captured while M2 reloads acc; Ti is taken straight from acc in SUM
   always_comb begin
      ti   = q15_round(acc);
      s_xr = sum_sat(ar, tr, 1'b0, scale);
      s_xi = sum_sat(ai, ti, 1'b0, scale);
      s_yr = sum_sat(ar, tr, 1'b1, scale);
      s_yi = sum_sat(ai, ti, 1'b1, scale);
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         ar <= '0; ai <= '0; br <= '0; bi <= '0; wr <= '0; wi <= '0;
         xr <= '0; xi <= '0; yr <= '0; yi <= '0;
         scale <= 1'b0; ie <= 1'b0; done <= 1'b0; ovf <= 1'b0;
         tr <= '0;
      end else begin
         if (reg_wr && !busy) begin
            case (off)
               OFF_AR: ar <= byte_merge(ar, per_din, per_we);
               OFF_AI: ai <= byte_merge(ai, per_din, per_we);
               OFF_BR: br <= byte_merge(br, per_din, per_we);
               OFF_BI: bi <= byte_merge(bi, per_din, per_we);
               OFF_WR: wr <= byte_merge(wr, per_din, per_we);
               OFF_WI: wi <= byte_merge(wi, per_din, per_we);
               default: ;
            endcase
         end
         if (reg_wr && (off == OFF_CTRL) && per_we[0]) begin
            scale <= per_din[1];
            ie    <= per_din[2];
         end
         if (reg_wr && (off == OFF_STATUS) && per_we[0]) begin
            if (per_din[1]) done <= 1'b0;
            if (per_din[2]) ovf  <= 1'b0;
         end
         // Placed after the W1C handling so a same-cycle set takes priority
         case (state)
            IDLE: if (start_req) begin
               state <= M0;
               done  <= 1'b0;
            end
            M0: state <= M1;
            M1: state <= M2;
            M2: begin
               tr    <= q15_round(acc);
               state <= M3;
            end
            M3: state <= SUM;
            SUM: begin
               xr    <= s_xr[15:0];
               xi    <= s_xi[15:0];
               yr    <= s_yr[15:0];
               yi    <= s_yi[15:0];
               done  <= 1'b1;
               if (s_xr[16] | s_xi[16] | s_yr[16] | s_yi[16]) ovf <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      per_dout = '0;
      if (reg_rd) begin
         case (off)
            OFF_AR:     per_dout = ar;
            OFF_AI:     per_dout = ai;
            OFF_BR:     per_dout = br;
            OFF_BI:     per_dout = bi;
            OFF_WR:     per_dout = wr;
            OFF_WI:     per_dout = wi;
            OFF_CTRL:   per_dout = {13'b0, ie, scale, 1'b0};
            OFF_STATUS: per_dout = {13'b0, ovf, done, busy};
            OFF_XR:     per_dout = xr;
            OFF_XI:     per_dout = xi;
            OFF_YR:     per_dout = yr;
            OFF_YI:     per_dout = yi;
            default:    per_dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_butterfly_per.sv
// Bench for fft_butterfly_per: transaction-level register/butterfly model
// checked every cycle, plus directed vectors with literal expectations.
module tb_fft_butterfly_per;

   localparam logic [13:0] BASE_W = 14'h0080;

   logic        mclk;
   logic        reset_n;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic        irq_fft;

   int checks = 0;
   int errors = 0;

   fft_butterfly_per #(.BASE_ADDR(15'h0100)) dut (
      .mclk     (mclk),
      .reset_n  (reset_n),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_en   (per_en),
      .per_we   (per_we),
      .per_dout (per_dout),
      .irq_fft  (irq_fft)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_op [6];
   logic [15:0] m_res [4];
   logic        m_scale, m_ie, m_done, m_ovf;
   int unsigned m_cnt;
   logic [15:0] c_res [4];
   logic        c_ovf;
   logic [3:0]  b_idx;

   assign b_idx = per_addr[3:0];

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                         input logic [1:0] we);
      return {we[1] ? d[15:8] : o[15:8], we[0] ? d[7:0] : o[7:0]};
   endfunction

   function automatic logic [16:0] sat(input longint v, input logic sc);
      longint s;
      s = sc ? (v >>> 1) : v;
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(s)};
   endfunction

   always_comb begin
      longint a_r, a_i, b_r, b_i, w_r, w_i, t_r, t_i;
      logic [16:0] q0, q1, q2, q3;
      a_r = longint'($signed(m_op[0]));
      a_i = longint'($signed(m_op[1]));
      b_r = longint'($signed(m_op[2]));
      b_i = longint'($signed(m_op[3]));
      w_r = longint'($signed(m_op[4]));
      w_i = longint'($signed(m_op[5]));
      t_r = (b_r * w_r - b_i * w_i + 16384) >>> 15;
      t_i = (b_r * w_i + b_i * w_r + 16384) >>> 15;
      q0 = sat(a_r + t_r, m_scale);
      q1 = sat(a_i + t_i, m_scale);
      q2 = sat(a_r - t_r, m_scale);
      q3 = sat(a_i - t_i, m_scale);
      c_res[0] = q0[15:0];
      c_res[1] = q1[15:0];
      c_res[2] = q2[15:0];
      c_res[3] = q3[15:0];
      c_ovf = q0[16] | q1[16] | q2[16] | q3[16];
   end

   // A START occupies the block for 5 cycles; results and DONE land at the end
   always @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) m_op[i] <= '0;
         for (int i = 0; i < 4; i++) m_res[i] <= '0;
         m_scale <= 1'b0; m_ie <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0;
         m_cnt <= 0;
      end else begin
         if (per_en && per_we != 2'b00 && per_addr[13:4] == BASE_W[13:4]) begin
            if (b_idx < 4'd6 && m_cnt == 0)
               m_op[b_idx[2:0]] <= merge(m_op[b_idx[2:0]], per_din, per_we);
            if (b_idx == 4'd6 && per_we[0]) begin
               m_scale <= per_din[1];
               m_ie    <= per_din[2];
               if (per_din[0] && m_cnt == 0) begin
                  m_cnt  <= 5;
                  m_done <= 1'b0;
               end
            end
            if (b_idx == 4'd7 && per_we[0]) begin
               if (per_din[1]) m_done <= 1'b0;
               if (per_din[2]) m_ovf  <= 1'b0;
            end
         end
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               for (int i = 0; i < 4; i++) m_res[i] <= c_res[i];
               m_done <= 1'b1;
               if (c_ovf) m_ovf <= 1'b1;
            end
         end
      end
   end

   function automatic logic [15:0] exp_reg(input logic [3:0] idx);
      if (idx < 4'd6) return m_op[idx[2:0]];
      if (idx == 4'd6) return {13'b0, m_ie, m_scale, 1'b0};
      if (idx == 4'd7) return {13'b0, m_ovf, m_done, m_cnt != 0};
      if (idx < 4'd12) return m_res[idx[1:0]];
      return 16'h0000;
   endfunction

   always @(negedge mclk) begin
      chk("irq_fft", {15'b0, irq_fft}, {15'b0, m_done & m_ie});
      if (per_en && per_we == 2'b00 && per_addr[13:4] == BASE_W[13:4])
         chk("per_dout_read", per_dout, exp_reg(b_idx));
      else
         chk("per_dout_idle", per_dout, 16'h0000);
   end

   // ---------------- bus tasks ----------------
   task automatic wrb(input logic [3:0] idx, input logic [15:0] d, input logic [1:0] we);
      per_addr = BASE_W + 14'(idx);
      per_din  = d;
      per_we   = we;
      per_en   = 1'b1;
      @(posedge mclk); #1;
      per_en = 1'b0;
      per_we = 2'b00;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [15:0] d);
      wrb(idx, d, 2'b11);
   endtask

   task automatic rd(input logic [3:0] idx, output logic [15:0] v);
      per_addr = BASE_W + 14'(idx);
      per_we   = 2'b00;
      per_en   = 1'b1;
      @(negedge mclk);
      v = per_dout;
      @(posedge mclk); #1;
      per_en = 1'b0;
   endtask

   task automatic rdc(input string name, input logic [3:0] idx, input logic [15:0] lit);
      logic [15:0] v;
      rd(idx, v);
      chk(name, v, lit);
   endtask

   task automatic wait_done(input string name);
      logic [15:0] v;
      bit ok;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         rd(4'd7, v);
         if (v[1]) ok = 1;
      end
      if (!ok) chk({name, "_timeout"}, 16'h0000, 16'h0001);
   endtask

   task automatic load(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i);
      wr(4'd0, a_r); wr(4'd1, a_i); wr(4'd2, b_r);
      wr(4'd3, b_i); wr(4'd4, w_r); wr(4'd5, w_i);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      int nb, first;
      reset_n  = 1'b1;
      per_addr = '0;
      per_din  = '0;
      per_en   = 1'b0;
      per_we   = 2'b00;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge mclk);
      #1 reset_n = 1'b1;

      // Reset values
      for (int i = 0; i < 12; i++) rdc("reset_reg", 4'(i), 16'h0000);
      rdc("unmapped_1a", 4'hD, 16'h0000);
      chk("reset_irq", {15'b0, irq_fft}, 16'h0000);

      // Byte-lane write
      wr(4'd0, 16'h1234);
      wrb(4'd0, 16'hFF55, 2'b01);
      rdc("byte_lane_lo", 4'd0, 16'h1255);
      wrb(4'd0, 16'hAAFF, 2'b10);
      rdc("byte_lane_hi", 4'd0, 16'hAA55);

      // Identity twiddle with busy-length measurement
      load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
      wr(4'd6, 16'h0001);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         rd(4'd7, v);
         if (v[0]) nb++;
      end
      chk("busy_cycles", 16'(nb), 16'd5);
      rdc("id_xr", 4'd8, 16'h6000);
      rdc("id_xi", 4'd9, 16'h0000);
      rdc("id_yr", 4'd10, 16'h2000);
      rdc("id_yi", 4'd11, 16'h0000);
      rdc("id_status", 4'd7, 16'h0002);

      // Rotation by -j
      load(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000);
      wr(4'd6, 16'h0001);
      wait_done("rot");
      rdc("rot_xr", 4'd8, 16'h0000);
      rdc("rot_xi", 4'd9, 16'hE000);
      rdc("rot_yr", 4'd10, 16'h0000);
      rdc("rot_yi", 4'd11, 16'h2000);

      // Saturation, then scaled rerun
      load(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
      wr(4'd6, 16'h0001);
      wait_done("sat");
      rdc("sat_xr", 4'd8, 16'h7FFF);
      rdc("sat_yr", 4'd10, 16'h0001);
      rdc("sat_status", 4'd7, 16'h0006);
      wr(4'd7, 16'h0004);
      rdc("ovf_cleared", 4'd7, 16'h0002);
      wr(4'd6, 16'h0003);
      wait_done("scale");
      rdc("scale_xr", 4'd8, 16'h7FFE);
      rdc("scale_yr", 4'd10, 16'h0000);
      rdc("scale_status", 4'd7, 16'h0002);

      // Writes during BUSY are ignored
      load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
      wr(4'd6, 16'h0001);
      wr(4'd0, 16'h1234);
      wr(4'd6, 16'h0001);
      wait_done("busy_prot");
      rdc("prot_ar", 4'd0, 16'h4000);
      rdc("prot_xr", 4'd8, 16'h6000);
      rdc("prot_yr", 4'd10, 16'h2000);

      // Interrupt rises on the DONE edge and drops after W1C
      wr(4'd6, 16'h0005);
      first = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge mclk);
         if (irq_fft && first < 0) first = i;
      end
      @(posedge mclk); #1;
      chk("irq_rise_cycle", 16'(first), 16'd5);
      chk("irq_high", {15'b0, irq_fft}, 16'h0001);
      wr(4'd7, 16'h0002);
      @(negedge mclk);
      chk("irq_after_w1c", {15'b0, irq_fft}, 16'h0000);
      @(posedge mclk); #1;

      // Reset in the middle of a computation
      wr(4'd6, 16'h0001);
      @(posedge mclk); #1;
      @(posedge mclk); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_irq", {15'b0, irq_fft}, 16'h0000);
      rdc("midrst_status", 4'd7, 16'h0000);
      reset_n = 1'b1;
      rdc("midrst_xr", 4'd8, 16'h0000);
      rdc("midrst_yr", 4'd10, 16'h0000);
      rdc("midrst_ar", 4'd0, 16'h0000);
      load(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
      wr(4'd6, 16'h0001);
      wait_done("after_rst");
      rdc("after_rst_xr", 4'd8, 16'h6000);
      rdc("after_rst_yr", 4'd10, 16'h2000);

      repeat (2) @(posedge mclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
